// File: rtl/uart_rx.sv
// UART receive engine: oversampled start qualification, majority-voted bit sampling,
// LSB-first deserialization with optional parity and stop checking.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_reg, state_next;
  logic [5:0]            edge_cnt_reg, edge_cnt_next;
  logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [2:0]            samples_reg, samples_next;
  logic [5:0]            presc_reg, presc_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  par_err_reg, par_err_next;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  dv_reg, dv_next;
  logic                  pe_reg, pe_next;
  logic                  se_reg, se_next;

  logic [5:0] presc_legal;
  logic [5:0] half;
  logic [5:0] last;
  logic [2:0] sample_hit;
  logic       voted;
  logic       bit_end;

  // Unsupported ratios fall back to 8x oversampling.
  assign presc_legal = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign half        = {1'b0, presc_reg[5:1]};
  assign last        = presc_reg - 6'd1;
  assign bit_end     = (edge_cnt_reg == last);
  assign voted       = (samples_reg[0] & samples_reg[1]) |
                       (samples_reg[0] & samples_reg[2]) |
                       (samples_reg[1] & samples_reg[2]);

  // Three sample points centred on the middle of the bit: P/2-1, P/2, P/2+1.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sample_hit
      assign sample_hit[gi] = (edge_cnt_reg == half + 6'(gi) - 6'd1);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      samples_reg  <= '0;
      presc_reg    <= 6'd8;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      par_err_reg  <= 1'b0;
      p_data_reg   <= '0;
      dv_reg       <= 1'b0;
      pe_reg       <= 1'b0;
      se_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      samples_reg  <= samples_next;
      presc_reg    <= presc_next;
      par_en_reg   <= par_en_next;
      par_typ_reg  <= par_typ_next;
      par_err_reg  <= par_err_next;
      p_data_reg   <= p_data_next;
      dv_reg       <= dv_next;
      pe_reg       <= pe_next;
      se_reg       <= se_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    samples_next  = samples_reg;
    presc_next    = presc_reg;
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;
    par_err_next  = par_err_reg;
    p_data_next   = p_data_reg;
    dv_next       = 1'b0;
    pe_next       = 1'b0;
    se_next       = 1'b0;

    if (state_reg != S_IDLE) begin
      edge_cnt_next = bit_end ? 6'd0 : edge_cnt_reg + 6'd1;
      for (int i = 0; i < 3; i++) begin
        if (sample_hit[i]) samples_next[i] = RX_IN;
      end
    end

    case (state_reg)
      S_IDLE: begin
        edge_cnt_next = '0;
        bit_cnt_next  = '0;
        if (!RX_IN) begin
          // Frame configuration is frozen here for the whole frame.
          state_next   = S_START;
          presc_next   = presc_legal;
          par_en_next  = PAR_EN;
          par_typ_next = PAR_TYP;
          par_err_next = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_next = voted ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next[bit_cnt_reg] = voted;
          if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_next = '0;
            state_next   = par_en_reg ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          if (voted != ((^shift_reg) ^ par_typ_reg)) begin
            par_err_next = 1'b1;
            pe_next      = 1'b1;
          end
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!voted) begin
            se_next = 1'b1;
          end else if (!par_err_reg) begin
            p_data_next = shift_reg;
            dv_next     = 1'b1;
          end
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign P_DATA       = p_data_reg;
  assign Data_Valid   = dv_reg;
  assign Parity_Error = pe_reg;
  assign Stop_Error   = se_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames, predicts output pulses (kind, cycle, data)
// into a scoreboard queue, and a monitor pops/compares them as the DUT pulses.
module tb_uart_rx;

  localparam int K_DV = 0;
  localparam int K_PE = 1;
  localparam int K_SE = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int   cyc;
  int   n_tests;
  int   n_fail;
  ev_t  sbq[$];
  ev_t  mon_ev;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RX_IN        (rx_in),
    .PAR_EN       (par_en),
    .PAR_TYP      (par_typ),
    .Prescale     (prescale),
    .P_DATA       (p_data),
    .Data_Valid   (data_valid),
    .Parity_Error (parity_error),
    .Stop_Error   (stop_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected pulses of one frame whose start is seen at edge t0.
  task automatic push_expect(input logic [7:0] d, input logic has_par, input logic ptyp,
                             input logic par_bit, input logic stop_bit, input int p, input int t0);
    ev_t  e;
    logic perr;
    int   n;
    perr = 1'b0;
    n    = has_par ? 11 : 10;
    if (has_par && (par_bit !== ((^d) ^ ptyp))) begin
      perr   = 1'b1;
      e.kind = K_PE; e.data = 8'h00; e.cyc = t0 + 10 * p;
      sbq.push_back(e);
    end
    if (!stop_bit) begin
      e.kind = K_SE; e.data = 8'h00; e.cyc = t0 + n * p;
      sbq.push_back(e);
    end else if (!perr) begin
      e.kind = K_DV; e.data = d; e.cyc = t0 + n * p;
      sbq.push_back(e);
    end
  endtask

  // Called at a negedge; each bit is held P clocks. glitch_i flips one clock, abort_i stops early.
  task automatic drive_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                             input logic stop_bit, input int p, input int glitch_i, input int abort_i);
    logic fb [0:10];
    int   nb;
    fb[0] = 1'b0;
    for (int b = 0; b < 8; b++) fb[b+1] = d[b];
    if (has_par) begin
      fb[9] = par_bit; fb[10] = stop_bit; nb = 11;
    end else begin
      fb[9] = stop_bit; fb[10] = 1'b1; nb = 10;
    end
    for (int i = 0; i < nb * p; i++) begin
      if (i == abort_i) break;
      rx_in = fb[i / p] ^ logic'(i == glitch_i);
      @(negedge clk);
    end
  endtask

  task automatic wait_events();
    for (int k = 0; k < 64; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (p_data !== 8'h00) begin n_fail++; $display("FAIL reset_p_data: got %h want 00", p_data); end
    n_tests++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b want 0", data_valid); end
    n_tests++;
    if (parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", parity_error); end
    n_tests++;
    if (stop_error !== 1'b0) begin n_fail++; $display("FAIL reset_se: got %b want 0", stop_error); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("[TB] reset: outputs checked");
  endtask

  task automatic test_start_glitch();
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (48) @(negedge clk);
    n_tests++;
    if (p_data !== 8'h00) begin n_fail++; $display("FAIL start_glitch_p_data: got %h want 00", p_data); end
    $display("[TB] start glitch: 3-clock low pulse rejected, P_DATA=%h", p_data);
  endtask

  task automatic test_parity_ok();
    int t0;
    prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
    @(negedge clk);
    t0 = cyc + 1;
    push_expect(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, t0);
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1, -1);
    rx_in = 1'b1;
    wait_events();
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL parity_ok_missing: %0d pulses pending want 0", sbq.size()); sbq.delete(); end
    repeat (16) @(negedge clk);
    n_tests++;
    if (p_data !== 8'hA5) begin n_fail++; $display("FAIL parity_ok_p_data: got %h want a5", p_data); end
    $display("[TB] P=8 even parity frame A5: P_DATA=%h", p_data);
  endtask

  task automatic test_parity_error();
    int t0;
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    @(negedge clk);
    t0 = cyc + 1;
    push_expect(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 16, t0);
    drive_frame(8'hA5, 1'b1, 1'b0, 1'b1, 16, -1, -1);
    rx_in = 1'b1;
    wait_events();
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL parity_err_missing: %0d pulses pending want 0", sbq.size()); sbq.delete(); end
    repeat (32) @(negedge clk);
    n_tests++;
    if (p_data !== 8'hA5) begin n_fail++; $display("FAIL parity_err_p_data: got %h want a5 (held)", p_data); end
    $display("[TB] P=16 odd parity frame A5 with bad parity: P_DATA=%h", p_data);
  endtask

  task automatic test_stop_error();
    int t0;
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk);
    t0 = cyc + 1;
    push_expect(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, t0);
    // Configuration changes after start detection must not affect this frame.
    fork
      begin
        repeat (20) @(negedge clk);
        prescale = 6'd8; par_en = 1'b1;
      end
      drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16, -1, -1);
    join
    rx_in = 1'b1;
    wait_events();
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL stop_err_missing: %0d pulses pending want 0", sbq.size()); sbq.delete(); end
    repeat (32) @(negedge clk);
    n_tests++;
    if (p_data !== 8'hA5) begin n_fail++; $display("FAIL stop_err_p_data: got %h want a5 (held)", p_data); end
    $display("[TB] P=16 frame 3C with stop=0: P_DATA=%h", p_data);
  endtask

  task automatic test_back_to_back();
    int t0;
    prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk);
    t0 = cyc + 1;
    push_expect(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32, t0);
    // Second start is seen one clock after the first frame's stop bit ends.
    push_expect(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 32, t0 + 10 * 32 + 1);
    drive_frame(8'h00, 1'b0, 1'b0, 1'b1, 32, 1 + 3 * 32 + 16, -1);
    drive_frame(8'hFF, 1'b0, 1'b0, 1'b1, 32, -1, -1);
    rx_in = 1'b1;
    wait_events();
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL b2b_missing: %0d pulses pending want 0", sbq.size()); sbq.delete(); end
    repeat (64) @(negedge clk);
    n_tests++;
    if (p_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_p_data: got %h want ff", p_data); end
    $display("[TB] P=32 back-to-back 00/FF with glitch: P_DATA=%h", p_data);
  endtask

  task automatic test_reset_midframe();
    int t0;
    prescale = 6'd16; par_en = 1'b0; par_typ = 1'b0;
    @(negedge clk);
    drive_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, -1, 5 * 16 + 8);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (p_data !== 8'h00) begin n_fail++; $display("FAIL midrst_p_data: got %h want 00", p_data); end
    n_tests++;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dv: got %b want 0", data_valid); end
    n_tests++;
    if (parity_error !== 1'b0) begin n_fail++; $display("FAIL midrst_pe: got %b want 0", parity_error); end
    n_tests++;
    if (stop_error !== 1'b0) begin n_fail++; $display("FAIL midrst_se: got %b want 0", stop_error); end
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    t0 = cyc + 1;
    push_expect(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16, t0);
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1, -1);
    rx_in = 1'b1;
    wait_events();
    n_tests++;
    if (sbq.size() != 0) begin n_fail++; $display("FAIL midrst_missing: %0d pulses pending want 0", sbq.size()); sbq.delete(); end
    repeat (32) @(negedge clk);
    n_tests++;
    if (p_data !== 8'h5A) begin n_fail++; $display("FAIL midrst_frame_p_data: got %h want 5a", p_data); end
    $display("[TB] reset during data bit 4, then frame 5A: P_DATA=%h", p_data);
  endtask

  initial begin
    cyc      = 0;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx_in    = 1'b1;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    prescale = 6'd8;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (data_valid) begin
            n_tests++;
            if (sbq.size() == 0) begin
              n_fail++; $display("FAIL dv_unexpected: Data_Valid=1 P_DATA=%h at cycle %0d, want no pulse", p_data, cyc);
            end else begin
              mon_ev = sbq.pop_front();
              if (mon_ev.kind != K_DV || mon_ev.cyc != cyc || p_data !== mon_ev.data) begin
                n_fail++;
                $display("FAIL dv_pulse: got Data_Valid data=%h cycle=%0d, want kind=%0d data=%h cycle=%0d",
                         p_data, cyc, mon_ev.kind, mon_ev.data, mon_ev.cyc);
              end else $display("[TB] Data_Valid data=%h at cycle %0d", p_data, cyc);
            end
          end
          if (parity_error) begin
            n_tests++;
            if (sbq.size() == 0) begin
              n_fail++; $display("FAIL pe_unexpected: Parity_Error=1 at cycle %0d, want no pulse", cyc);
            end else begin
              mon_ev = sbq.pop_front();
              if (mon_ev.kind != K_PE || mon_ev.cyc != cyc) begin
                n_fail++;
                $display("FAIL pe_pulse: got Parity_Error cycle=%0d, want kind=%0d cycle=%0d", cyc, mon_ev.kind, mon_ev.cyc);
              end else $display("[TB] Parity_Error at cycle %0d", cyc);
            end
          end
          if (stop_error) begin
            n_tests++;
            if (sbq.size() == 0) begin
              n_fail++; $display("FAIL se_unexpected: Stop_Error=1 at cycle %0d, want no pulse", cyc);
            end else begin
              mon_ev = sbq.pop_front();
              if (mon_ev.kind != K_SE || mon_ev.cyc != cyc) begin
                n_fail++;
                $display("FAIL se_pulse: got Stop_Error cycle=%0d, want kind=%0d cycle=%0d", cyc, mon_ev.kind, mon_ev.cyc);
              end else $display("[TB] Stop_Error at cycle %0d", cyc);
            end
          end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
      end
    join_none

    test_reset();
    test_start_glitch();
    test_parity_ok();
    test_parity_error();
    test_stop_error();
    test_back_to_back();
    test_reset_midframe();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive engine for the UART, the receive-side counterpart of the TX path's framing and parity generation. It oversamples `RX_IN` at a selectable prescale, detects and qualifies the start bit, deserializes 8 data bits LSB-first, and checks the optional parity bit and the stop bit. It presents each accepted byte on `P_DATA` with a one-cycle `Data_Valid` strobe, and flags parity and stop errors for the downstream register or FIFO logic.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`  in  1: single clock; oversampling clock, Prescale × baud.
- `rst_n`  in  1: asynchronous, active-low reset.
- `RX_IN`  in  1: serial line; idles high. Already synchronized upstream.
- `PAR_EN`  in  1: 1 means the frame carries a parity bit between the data bits and the stop bit.
- `PAR_TYP`  in  1: parity type; 0 = even, 1 = odd. Same encoding as the TX parity generator.
- `Prescale`  in  6: oversampling ratio. Legal values are 8, 16 and 32; any other value is treated as 8.
- `P_DATA`  out  DATA_WIDTH: last accepted byte, held until the next accepted byte.
- `Data_Valid`  out  1: one-cycle pulse when a byte is accepted.
- `Parity_Error`  out  1: one-cycle pulse when the received parity bit mismatches.
- `Stop_Error`  out  1: one-cycle pulse when the stop bit is sampled as 0.

## Operation
- **Configuration latch.** `Prescale`, `PAR_EN` and `PAR_TYP` are latched at start detection and used for the whole frame. Mid-frame changes have no effect.
- **Counters.**
  - `edge_cnt` runs 0..P-1 per bit, where P is the latched prescale.
  - `bit_cnt` runs 0..DATA_WIDTH-1 during DATA.
- **Bit sampling.** Each bit is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the majority vote of these three samples. The voted bit is consumed at `edge_cnt` = P-1.
- **IDLE.** When `RX_IN` = 0 is sampled, go to START with `edge_cnt` = 0 on the next cycle.
- **START.** At `edge_cnt` = P-1:
  - voted bit 0: go to DATA.
  - voted bit 1: treat as a glitch and return to IDLE. No output changes.
- **DATA.** At each `edge_cnt` = P-1, shift the voted bit into the shift register at position `bit_cnt` (LSB first). After bit DATA_WIDTH-1:
  - go to PARITY if `PAR_EN` = 1;
  - otherwise go to STOP.
- **PARITY.**
  - Expected parity is XOR of the data bits when even, and XNOR of the data bits when odd.
  - At `edge_cnt` = P-1, a mismatch sets the internal error flag and pulses `Parity_Error`.
  - Always go to STOP.
- **STOP.** At `edge_cnt` = P-1:
  - voted bit 0: pulse `Stop_Error`.
  - no parity error and no stop error in this frame: load `P_DATA` from the shift register and pulse `Data_Valid`.
  - In all cases return to IDLE.
- **Error frames.** A frame with any error never updates `P_DATA` and never asserts `Data_Valid`.
- **Back-to-back frames.** A start bit arriving immediately after the stop bit is detected in IDLE on the following cycle; no idle gap is required.
- **Line held low after a stop error.** IDLE treats the low line as a new start bit.

## Timing
- **Reset values** (async on `rst_n` low, mid-frame included):
  - FSM returns to IDLE; counters, shift register and error flags are cleared.
  - `P_DATA` = 0, `Data_Valid` = 0, `Parity_Error` = 0, `Stop_Error` = 0.
  - After release, a frame already in progress on the line is received only from its next start edge.
- **Reference point.** Let t0 be the rising edge at which IDLE samples `RX_IN` = 0, and N the frame length in bits (10 without parity, 11 with parity).
  - Bit k (start bit = 0) occupies edges t0+1+k·P .. t0+(k+1)·P.
- **Output edges.** All outputs are registered.
  - `Data_Valid` and `Stop_Error` are high for exactly one cycle after edge t0+N·P.
  - `Parity_Error` is high for exactly one cycle after edge t0+10·P.
  - `P_DATA` changes on the same edge that raises `Data_Valid`.
- **Throughput.** Minimum frame spacing is N·P+1 clocks from start detection to the next start detection.
- **Simultaneous errors.** `Parity_Error` and `Stop_Error` in the same frame pulse at their own bit ends, one bit apart.

## Test plan
- Prescale=8, `PAR_EN`=1, `PAR_TYP`=0, frame 0xA5 with parity bit 0 and stop 1 -> `P_DATA`=0xA5, `Data_Valid` pulses once after edge t0+88, no errors.
- Prescale=16, `PAR_TYP`=1, frame 0xA5 with parity bit 0 (wrong) -> `Parity_Error` pulses after t0+160; no `Data_Valid`; `P_DATA` keeps its previous value.
- Prescale=16, `PAR_EN`=0, 0x3C with stop bit 0 -> `Stop_Error` pulses after t0+160; no `Data_Valid`.
- Prescale=16, `RX_IN` low for 3 clocks then high -> START rejects the bit; FSM returns to IDLE; all outputs stay 0.
- Prescale=32, `PAR_EN`=0, back-to-back 0x00 then 0xFF with no gap, plus a single-cycle glitch injected at sample point P/2 of data bit 2 -> majority vote masks the glitch; two `Data_Valid` pulses with `P_DATA`=0x00 then 0xFF.
- `rst_n` asserted during data bit 4 of a frame -> all outputs 0 immediately; the next clean frame 0x5A is received correctly.
